// File: rtl/seq_sampler_multi_pkg.sv
// Shared definitions for the multi-track step sequencer: state encoding and
// the one-hot key qualifier.
package seq_sampler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REC  = 2'b01,
        ST_PLAY = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // True when exactly one bit of v is set; callers zero-extend narrower keys.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/seq_sampler_multi_if.sv
// Control/status bundle between the key/tempo sources and the sequencer.
// Strobes (step, tick, clear) are single-cycle enables sampled on the clock;
// rec/play/loop are levels; there is no backpressure anywhere on this bus.
interface seq_sampler_multi_if #(
    parameter int KEY_W      = 5,
    parameter int DEPTH      = 8,
    parameter int NUM_TRACKS = 2
);
    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [KEY_W-1:0] key;
    logic             step;
    logic             tick;
    logic [TW-1:0]    track_sel;
    logic             rec;
    logic             play;
    logic             loop;
    logic             clear;
    logic [KEY_W-1:0] out;
    logic [1:0]       state;
    logic [LW-1:0]    track_len;
    logic             full;

    modport master (
        output key, step, tick, track_sel, rec, play, loop, clear,
        input  out, state, track_len, full
    );

    modport slave (
        input  key, step, tick, track_sel, rec, play, loop, clear,
        output out, state, track_len, full
    );

endinterface

// File: rtl/seq_sampler_multi_track_mem.sv
// One sequencer track: DEPTH x KEY_W register file appended at its length
// counter, with a clear port and asynchronous read.
module seq_track_mem #(
    parameter int KEY_W = 5,
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             clr,
    input  logic [KEY_W-1:0] wdata,
    input  logic [LW-1:0]    raddr,
    output logic [KEY_W-1:0] rdata,
    output logic [LW-1:0]    len
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [KEY_W-1:0] mem [DEPTH];
    logic             can_write;

    assign can_write = we && (len < LW'(DEPTH));

    // Sample storage carries no reset; only the length decides what is valid.
    always_ff @(posedge clk) begin
        if (can_write) begin
            mem[len[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len <= '0;
        end else if (clr) begin
            len <= '0;
        end else if (can_write) begin
            len <= len + LW'(1);
        end
    end

    assign rdata = (raddr < LW'(DEPTH)) ? mem[raddr[AW-1:0]] : '0;

endmodule

// File: rtl/seq_sampler_multi.sv
// Multi-track step sequencer: live key echo, per-track recording and
// tick-paced playback of the track latched on entry to REC/PLAY.
module seq_sampler_multi
    import seq_sampler_pkg::*;
#(
    parameter int KEY_W      = 5,
    parameter int DEPTH      = 8,
    parameter int NUM_TRACKS = 2
) (
    input logic                clk,
    input logic                reset,
    seq_sampler_multi_if.slave bus
);
    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [KEY_W-1:0] REC_MARK = {1'b1, {(KEY_W-1){1'b0}}};

    state_t           st;
    logic [KEY_W-1:0] out_r;
    logic [LW-1:0]    ptr;
    logic [TW-1:0]    trk;

    logic                  valid_key;
    logic [NUM_TRACKS-1:0] we;
    logic [NUM_TRACKS-1:0] clr;
    logic [KEY_W-1:0]      rdata   [NUM_TRACKS];
    logic [LW-1:0]         len_arr [NUM_TRACKS];
    logic [LW-1:0]         sel_len;
    logic [LW-1:0]         play_len;
    logic [KEY_W-1:0]      play_data;

    assign valid_key = is_onehot(32'(bus.key));

    for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_track
        seq_track_mem #(
            .KEY_W (KEY_W),
            .DEPTH (DEPTH),
            .LW    (LW)
        ) u_track (
            .clk   (clk),
            .reset (reset),
            .we    (we[gi]),
            .clr   (clr[gi]),
            .wdata (bus.key),
            .raddr (ptr),
            .rdata (rdata[gi]),
            .len   (len_arr[gi])
        );
    end

    // Writes follow the latched track; clear and status follow the live select.
    always_comb begin
        we        = '0;
        clr       = '0;
        sel_len   = '0;
        play_len  = '0;
        play_data = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            we[i]  = (st == ST_REC) && bus.step && valid_key && (trk == TW'(i));
            clr[i] = (st == ST_IDLE) && bus.clear && (bus.track_sel == TW'(i));
            if (bus.track_sel == TW'(i)) begin
                sel_len = len_arr[i];
            end
            if (trk == TW'(i)) begin
                play_len  = len_arr[i];
                play_data = rdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= ST_IDLE;
            out_r <= '0;
            ptr   <= '0;
            trk   <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (bus.rec) begin
                        st    <= ST_REC;
                        trk   <= bus.track_sel;
                        out_r <= REC_MARK;
                    end else if (bus.play && (sel_len != '0)) begin
                        st    <= ST_PLAY;
                        trk   <= bus.track_sel;
                        ptr   <= '0;
                        out_r <= '0;
                    end else begin
                        out_r <= valid_key ? bus.key : '0;
                    end
                end
                ST_REC: begin
                    if (!bus.rec) begin
                        st    <= ST_IDLE;
                        out_r <= '0;
                    end else begin
                        out_r <= REC_MARK;
                    end
                end
                ST_PLAY: begin
                    if (!bus.play) begin
                        st    <= ST_IDLE;
                        out_r <= '0;
                        ptr   <= '0;
                    end else if (bus.tick) begin
                        out_r <= play_data;
                        // Last stored step just emitted: wrap or park in DONE.
                        if ((ptr + LW'(1)) >= play_len) begin
                            if (bus.loop) begin
                                ptr <= '0;
                            end else begin
                                ptr <= ptr + LW'(1);
                                st  <= ST_DONE;
                            end
                        end else begin
                            ptr <= ptr + LW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.play) begin
                        st    <= ST_IDLE;
                        out_r <= '0;
                        ptr   <= '0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.state     = st;
    assign bus.track_len = sel_len;
    assign bus.full      = (sel_len == LW'(DEPTH));

endmodule
